// File: rtl/fsm_defs_pkg.sv
// State encodings shared by the button input stage and the 2-bit counter block.
// The counter reuses STATE_W so both blocks agree on the state-register width.
package fsm_defs;

  localparam int STATE_W = 2;

  localparam logic [STATE_W-1:0] IDLE        = 2'b00;
  localparam logic [STATE_W-1:0] PRESS_CHK   = 2'b01;
  localparam logic [STATE_W-1:0] HELD        = 2'b10;
  localparam logic [STATE_W-1:0] RELEASE_CHK = 2'b11;

  // The debounced level is high once a press is accepted, until its release is confirmed.
  function automatic logic is_pressed(input logic [STATE_W-1:0] s);
    return (s == HELD) || (s == RELEASE_CHK);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reusable for any other asynchronous input that needs to be brought into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;

  // NOTE: sequential state uses non-blocking assignments so s1 and q update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      q  <= 1'b0;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_pulse_fsm.sv
// Debounces a raw push-button level and emits one registered pulse per confirmed press,
// plus the debounced level for LEDs/debug.
module button_pulse_fsm
  import fsm_defs::*;
#(
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_in,
  output logic               pulse,
  output logic               btn_level,
  output logic [STATE_W-1:0] state_dbg
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic               s2;
  logic [STATE_W-1:0] state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               pulse_next;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (s2)
  );

  // NOTE: every signal gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    pulse_next = 1'b0;
    case (state)
      IDLE: begin
        if (s2) begin
          state_next = PRESS_CHK;
          cnt_next   = '0;
        end
      end
      PRESS_CHK: begin
        if (!s2) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
          pulse_next = 1'b1;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!s2) begin
          state_next = RELEASE_CHK;
          cnt_next   = '0;
        end
      end
      RELEASE_CHK: begin
        // Bouncing back high returns to HELD without re-arming the pulse.
        if (s2) begin
          state_next = HELD;
        end else if (cnt == CNT_LAST) begin
          state_next = IDLE;
        end else begin
          cnt_next = cnt + CNT_ONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      pulse     <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      pulse     <= pulse_next;
      btn_level <= is_pressed(state_next);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_button_pulse_fsm.sv
// Self-checking bench for button_pulse_fsm: expected pulse edges are queued when the
// button is driven and matched against the observed pulses.
module tb_button_pulse_fsm;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_in;
  logic       pulse;
  logic       btn_level;
  logic [1:0] state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_q[$];
  logic [1:0] ctr;

  button_pulse_fsm #(.DEBOUNCE_CYCLES(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .pulse     (pulse),
    .btn_level (btn_level),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the downstream 2-bit counter: one increment per pulse.
  always @(posedge clk or posedge rst) begin
    if (rst) ctr <= 2'b00;
    else if (pulse) ctr <= ctr + 2'b01;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse must appear after edge D+3 counted from the last rise of btn_in.
  task automatic expect_press();
    exp_q.push_back(cyc + D + 3);
  endtask

  always @(negedge clk) begin
    if (!rst) check("cnt_bound", 32'(dut.cnt <= 3'(D - 1)), 32'd1);
    if (pulse) begin
      if (exp_q.size() == 0) check("pulse_unexpected", 32'(pulse), 32'd0);
      else check("pulse_cycle", cyc, exp_q.pop_front());
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  logic [1:0] seq [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  initial begin
    // 1. Button held through reset.
    rst    = 1'b1;
    btn_in = 1'b1;
    #8;
    check("rst_pulse", 32'(pulse), 32'd0);
    check("rst_level", 32'(btn_level), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);
    #4;
    rst = 1'b0;
    expect_press();
    tick(20);
    check("t1_level", 32'(btn_level), 32'd1);
    check("t1_state", 32'(state_dbg), 32'h2);
    check("t1_q_empty", exp_q.size(), 32'd0);
    btn_in = 1'b0;
    tick(10);
    check("t1_rel_state", 32'(state_dbg), 32'h0);
    check("t1_rel_level", 32'(btn_level), 32'd0);

    // 2. Clean press held 200 ns.
    btn_in = 1'b1;
    expect_press();
    tick(20);
    check("t2_level", 32'(btn_level), 32'd1);
    check("t2_state", 32'(state_dbg), 32'h2);
    check("t2_q_empty", exp_q.size(), 32'd0);
    btn_in = 1'b0;
    tick(10);
    check("t2_rel_state", 32'(state_dbg), 32'h0);

    // 3. 20 ns glitch is rejected.
    btn_in = 1'b1;
    tick(2);
    btn_in = 1'b0;
    tick(1);
    check("t3_in_chk", 32'(state_dbg), 32'h1);
    check("t3_level_chk", 32'(btn_level), 32'd0);
    tick(4);
    check("t3_state", 32'(state_dbg), 32'h0);
    check("t3_level", 32'(btn_level), 32'd0);

    // 4. Release bounce: 10 -> 11 -> 10 -> 11 -> 00 with no extra pulse.
    btn_in = 1'b1;
    expect_press();
    tick(15);
    check("t4_held", 32'(state_dbg), 32'h2);
    btn_in = 1'b0;
    tick(2);
    btn_in = 1'b1;
    tick(1);
    check("t4_rc1", 32'(state_dbg), 32'h3);
    check("t4_rc1_level", 32'(btn_level), 32'd1);
    tick(2);
    check("t4_back_held", 32'(state_dbg), 32'h2);
    btn_in = 1'b0;
    tick(3);
    check("t4_rc2", 32'(state_dbg), 32'h3);
    tick(3);
    check("t4_rc2_late", 32'(state_dbg), 32'h3);
    check("t4_level_late", 32'(btn_level), 32'd1);
    tick(1);
    check("t4_idle", 32'(state_dbg), 32'h0);
    check("t4_level_idle", 32'(btn_level), 32'd0);
    check("t4_q_empty", exp_q.size(), 32'd0);

    // 5. Reset three cycles into PRESS_CHK discards the press.
    btn_in = 1'b1;
    tick(3);
    check("t5_in_chk", 32'(state_dbg), 32'h1);
    tick(2);
    rst    = 1'b1;
    btn_in = 1'b0;
    #1;
    check("t5_rst_state", 32'(state_dbg), 32'h0);
    check("t5_rst_cnt", 32'(dut.cnt), 32'd0);
    check("t5_rst_pulse", 32'(pulse), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(15);
    check("t5_state", 32'(state_dbg), 32'h0);
    check("t5_ctr", 32'(ctr), 32'd0);

    // 6. Four bouncy presses -> counter 01, 10, 11, 00.
    for (int i = 0; i < 4; i++) begin
      btn_in = 1'b1;
      tick(1);
      btn_in = 1'b0;
      tick(1);
      btn_in = 1'b1;
      expect_press();
      tick(20);
      check($sformatf("t6_ctr%0d", i), 32'(ctr), 32'(seq[i]));
      btn_in = 1'b0;
      tick(12);
    end
    check("t6_state", 32'(state_dbg), 32'h0);
    check("final_q_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
